// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: funct3/state/signed encodings, MIN constants and operand/result helpers for div_issue_ctrl
package div_issue_ctrl_pkg;
  localparam logic [2:0] FN_DIV = 3'b100;
  localparam logic [2:0] FN_DIVU = 3'b101;
  localparam logic [2:0] FN_REM = 3'b110;
  localparam logic [2:0] FN_REMU = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN32 = 32'h8000_0000;
  localparam logic [1:0] SGN_SIGNED = 2'b11;
  localparam logic [1:0] SGN_UNSIGNED = 2'b00;
  function automatic logic [63:0] extend_op(input logic [63:0] x, input logic word, input logic sgn);
    return word ? {{32{sgn & x[31]}}, x[31:0]} : x;
  endfunction
  function automatic logic [63:0] pick_result(input logic [63:0] q, input logic [63:0] r, input logic rem, input logic word);
    logic [63:0] s;
    s = rem ? r : q;
    return word ? {{32{s[31]}}, s[31:0]} : s;
  endfunction
endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: request, divider and writeback signals of div_issue_ctrl; slave = controller side, master = pipeline/divider side
interface div_issue_ctrl_if #(parameter int XLEN = 64);
  logic Flush;
  logic In_Valid;
  logic In_Ready;
  logic [2:0] In_Funct;
  logic In_Word;
  logic [XLEN-1:0] In_Src1;
  logic [XLEN-1:0] In_Src2;
  logic [4:0] In_Rd;
  logic Div_Valid;
  logic Div_Flush;
  logic Div_Divw;
  logic [1:0] Div_Signed;
  logic [XLEN-1:0] Div_Dividend;
  logic [XLEN-1:0] Div_Divisor;
  logic Div_Ready;
  logic Div_OutValid;
  logic [XLEN-1:0] Div_Quotient;
  logic [XLEN-1:0] Div_Remainder;
  logic Out_Valid;
  logic Out_Ready;
  logic [XLEN-1:0] Out_Data;
  logic [4:0] Out_Rd;
  modport slave (
    input Flush, In_Valid, In_Funct, In_Word, In_Src1, In_Src2, In_Rd,
    input Div_Ready, Div_OutValid, Div_Quotient, Div_Remainder, Out_Ready,
    output In_Ready, Div_Valid, Div_Flush, Div_Divw, Div_Signed, Div_Dividend, Div_Divisor,
    output Out_Valid, Out_Data, Out_Rd
  );
  modport master (
    output Flush, In_Valid, In_Funct, In_Word, In_Src1, In_Src2, In_Rd,
    output Div_Ready, Div_OutValid, Div_Quotient, Div_Remainder, Out_Ready,
    input In_Ready, Div_Valid, Div_Flush, Div_Divw, Div_Signed, Div_Dividend, Div_Divisor,
    input Out_Valid, Out_Data, Out_Rd
  );
endinterface

// File: rtl/div_issue_ctrl_special.sv
// div_special_case: divide-by-zero / signed-overflow detection and results (in: extended operands, word, sgn; out: is_special, q, r)
module div_special_case
  import div_issue_ctrl_pkg::*;
(
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  input  logic        word,
  input  logic        sgn,
  output logic        is_special,
  output logic [63:0] q,
  output logic [63:0] r
);
  logic div_zero;
  logic ovf;
  always_comb begin
    div_zero = word ? (divisor[31:0] == '0) : (divisor == '0);
    ovf = sgn & (word ? (dividend[31:0] == MIN32 && &divisor[31:0]) : (dividend == MIN64 && &divisor));
    is_special = div_zero | ovf;
    q = div_zero ? '1 : dividend;
    r = div_zero ? dividend : '0;
  end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: RV64M divide issue control (ports clock, reset, io slave modport); optional one-entry result cache under DIV_RESULT_CACHE_EN
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic clock,
  input logic reset,
  div_issue_ctrl_if.slave io
);
  state_t state, nxt;
  logic rem_q;
  logic [4:0] rd_q;
  logic [XLEN-1:0] data_q;
  logic sgn_in, rem_in, accept, fast, div_done, sp_is, hit;
  logic [XLEN-1:0] a_ext, b_ext, sp_q, sp_r, hit_q, hit_r, fast_data;
  assign sgn_in = io.In_Funct inside {FN_DIV, FN_REM};
  assign rem_in = !(io.In_Funct inside {FN_DIV, FN_DIVU});
  assign a_ext = extend_op(io.In_Src1, io.In_Word, sgn_in);
  assign b_ext = extend_op(io.In_Src2, io.In_Word, sgn_in);
  div_special_case u_special (
    .dividend(a_ext),
    .divisor(b_ext),
    .word(io.In_Word),
    .sgn(sgn_in),
    .is_special(sp_is),
    .q(sp_q),
    .r(sp_r)
  );
`ifdef DIV_RESULT_CACHE_EN
  logic c_valid, c_w;
  logic [1:0] c_s;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;
  assign hit = c_valid && c_a == a_ext && c_b == b_ext && c_w == io.In_Word && c_s == (sgn_in ? SGN_SIGNED : SGN_UNSIGNED);
  assign hit_q = c_q;
  assign hit_r = c_r;
  always_ff @(posedge clock)
    if (reset) c_valid <= 1'b0;
    else if (div_done) begin
      c_valid <= 1'b1;
      c_a <= io.Div_Dividend;
      c_b <= io.Div_Divisor;
      c_w <= io.Div_Divw;
      c_s <= io.Div_Signed;
      c_q <= io.Div_Quotient;
      c_r <= io.Div_Remainder;
    end
`else
  assign hit = 1'b0;
  assign hit_q = '0;
  assign hit_r = '0;
`endif
  assign fast = sp_is | hit;
  assign fast_data = sp_is ? pick_result(sp_q, sp_r, rem_in, io.In_Word) : pick_result(hit_q, hit_r, rem_in, io.In_Word);
  assign accept = state == S_IDLE && io.In_Valid && !io.Flush;
  assign div_done = state == S_WAIT && io.Div_OutValid && !io.Flush;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = accept ? (fast ? S_DONE : S_ISSUE) : S_IDLE;
      S_ISSUE: nxt = io.Flush ? S_IDLE : (io.Div_Ready ? S_WAIT : S_ISSUE);
      S_WAIT: nxt = io.Flush ? S_IDLE : (io.Div_OutValid ? S_DONE : S_WAIT);
      S_DONE: nxt = (io.Flush || io.Out_Ready) ? S_IDLE : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_IDLE;
      rem_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      io.Div_Divw <= 1'b0;
      io.Div_Signed <= SGN_UNSIGNED;
      io.Div_Dividend <= '0;
      io.Div_Divisor <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        rem_q <= rem_in;
        rd_q <= io.In_Rd;
        io.Div_Divw <= io.In_Word;
        io.Div_Signed <= sgn_in ? SGN_SIGNED : SGN_UNSIGNED;
        io.Div_Dividend <= a_ext;
        io.Div_Divisor <= b_ext;
      end
      if (accept && fast) data_q <= fast_data;
      if (div_done) data_q <= pick_result(io.Div_Quotient, io.Div_Remainder, rem_q, io.Div_Divw);
    end
  assign io.In_Ready = state == S_IDLE && !io.Flush;
  assign io.Div_Valid = state == S_ISSUE;
  assign io.Div_Flush = io.Flush && (state == S_ISSUE || state == S_WAIT);
  assign io.Out_Valid = state == S_DONE;
  assign io.Out_Data = data_q;
  assign io.Out_Rd = rd_q;
endmodule
